// File: rtl/startup_seq_if.sv
// Control/status bundle between the power-up sequencer and its surroundings.
// The controller side (master) drives ready/ack/retry; the sequencer (slave) returns enables and status.
interface startup_seq_if #(
    parameter int N_STG = 4
) ();
    logic             ready;
    logic [N_STG-1:0] ack;
    logic             retry;
    logic [N_STG-1:0] en;
    logic             busy;
    logic             done;
    logic             err;
    logic [2:0]       err_stg;

    modport master (
        output ready, ack, retry,
        input  en, busy, done, err, err_stg
    );

    modport slave (
        input  ready, ack, retry,
        output en, busy, done, err, err_stg
    );
endinterface

// File: rtl/startup_seq.sv
// Power-up sequencer: after ready rises, enables N_STG stages one by one, each
// waiting for its ack (with timeout) and separated by a fixed idle gap.
module startup_seq #(
    parameter int N_STG   = 4,
    parameter int GAP     = 4,
    parameter int TIMEOUT = 16
) (
    input  logic         clk,
    input  logic         rstn,
    startup_seq_if.slave bus,
    output logic [2:0]   dbg_state_o
);
    localparam int MAXV = (GAP > TIMEOUT) ? GAP : TIMEOUT;
    localparam int CW   = (MAXV > 1) ? $clog2(MAXV) : 1;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_EN   = 3'd1,
        S_GAP  = 3'd2,
        S_DONE = 3'd3,
        S_ERR  = 3'd4
    } state_t;

    state_t           state_q;
    logic [N_STG-1:0] en_q;
    logic             busy_q;
    logic             done_q;
    logic             err_q;
    logic [2:0]       err_stg_q;
    logic [2:0]       stg_q;
    logic [CW-1:0]    cnt_q;

    logic             ack_cur;
    logic [N_STG-1:0] next_mask;

    // Decode the current stage's ack and the next stage's enable bit without
    // indexing N_STG-wide vectors by the 3-bit stage number.
    always_comb begin
        ack_cur   = 1'b0;
        next_mask = '0;
        for (int i = 0; i < N_STG; i++) begin
            if (stg_q == 3'(i)) ack_cur = bus.ack[i];
            if (stg_q + 3'd1 == 3'(i)) next_mask[i] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= S_IDLE;
            en_q      <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            err_stg_q <= 3'd0;
            stg_q     <= 3'd0;
            cnt_q     <= '0;
        end else if (state_q != S_IDLE && !bus.ready) begin
            // Losing ready aborts everything; err_stg survives for diagnosis.
            state_q <= S_IDLE;
            en_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            stg_q   <= 3'd0;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.ready) begin
                        state_q <= S_EN;
                        stg_q   <= 3'd0;
                        en_q    <= N_STG'(1);
                        busy_q  <= 1'b1;
                        cnt_q   <= '0;
                    end
                end
                S_EN: begin
                    if (ack_cur) begin
                        cnt_q <= '0;
                        if (stg_q == 3'(N_STG - 1)) begin
                            state_q <= S_DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= S_GAP;
                        end
                    end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                        state_q   <= S_ERR;
                        en_q      <= '0;
                        busy_q    <= 1'b0;
                        err_q     <= 1'b1;
                        err_stg_q <= stg_q;
                        cnt_q     <= '0;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                S_GAP: begin
                    if (cnt_q == CW'(GAP - 1)) begin
                        state_q <= S_EN;
                        stg_q   <= stg_q + 3'd1;
                        en_q    <= en_q | next_mask;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                S_DONE: begin
                end
                S_ERR: begin
                    if (bus.retry) begin
                        state_q <= S_IDLE;
                        err_q   <= 1'b0;
                        cnt_q   <= '0;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign bus.en      = en_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.err     = err_q;
    assign bus.err_stg = err_stg_q;
    assign dbg_state_o = state_q;
endmodule

// File: doc/startup_seq.md
# startup_seq

Power-up sequencer that consumes the level `ready` flag from the power-on delay counter, which rises once after reset and stays high. Once `ready` is seen, the block enables N downstream stages one at a time. Each stage must acknowledge within a timeout, and a fixed gap separates consecutive enables. It reports busy, done and error status to the rest of the design.

## Interface
- `N_STG`, 4: number of sequenced stages; legal range 1..8.
- `GAP`, 4: idle cycles between one stage's ack and the next stage's enable; must be ≥1.
- `TIMEOUT`, 16: maximum edges to wait for a stage ack; must be ≥1.
- `clk` input 1: single clock; all logic on its rising edge.
- `rstn` input 1: reset, asynchronous, active-low.
- `ready` input 1: start qualifier from the upstream power-on delay counter; level, synchronous to `clk`.
- `ack` input N_STG: per-stage acknowledge; only `ack[stg]` of the current stage is examined.
- `retry` input 1: single-cycle pulse; leaves the ERR state.
- `en` output N_STG: cumulative stage enables; bits 0..stg are high.
- `busy` output 1: high while the sequence is in progress (EN or GAP state).
- `done` output 1: high once all stages are acknowledged.
- `err` output 1: high after a stage timeout.
- `err_stg` output 3: index of the stage that timed out; valid while `err`=1.

## Operation
- All outputs are registered.
- Reset values: state=IDLE, `en`=0, `busy`=0, `done`=0, `err`=0, `err_stg`=0, `stg`=0, counter `cnt`=0.
- `cnt` is wide enough for max(GAP, TIMEOUT)-1. It is cleared on every state entry.
- Priority on every edge: `ready`=0 in any non-IDLE state forces IDLE, with `en`, `busy`, `done`, `err` and `stg` all cleared.
- IDLE:
  - `ready`=1 → EN with `stg`=0, `en[0]`=1, `busy`=1.
- EN (waiting on `ack[stg]`):
  - `ack[stg]`=1 and `stg`=N_STG-1 → DONE, `busy`=0, `done`=1.
  - `ack[stg]`=1 and `stg`<N_STG-1 → GAP.
  - `ack[stg]`=0 and `cnt`=TIMEOUT-1 → ERR: `en`=0, `busy`=0, `err`=1, `err_stg`=`stg`.
  - Otherwise `cnt`+1.
- GAP:
  - `cnt`=GAP-1 → EN with `stg`+1 and `en[stg+1]` set. Lower enable bits stay high.
  - Otherwise `cnt`+1.
- DONE: holds until `ready` falls. `ack` and `retry` are ignored.
- ERR: holds with `err`=1. `retry`=1 → IDLE with `err`=0 and `err_stg` kept; the sequence restarts on the next edge if `ready` is still 1.
- `ack` of already-accepted stages is not monitored. An early `ack[stg+1]` is ignored until that stage is in EN.
- `retry` outside ERR has no effect.
- Asserting `rstn` mid-sequence drops all outputs immediately, asynchronously, to their reset values.

## Timing
- `ready` sampled high at edge k → `en[0]`=1 and `busy`=1 after edge k.
- An ack is accepted at the first edge in EN where `ack[stg]`=1. The earliest is edge k+1 for stage 0.
- Timeout:
  - The TIMEOUT edges after an enable rises are checked for ack.
  - With ack never high, ERR is entered at the TIMEOUT-th edge after the enable (k+TIMEOUT for stage 0).
  - An ack at that same edge wins over timeout.
- GAP occupies exactly GAP cycles. With acks always high, consecutive enables are GAP+1 cycles apart.
- Done latency with acks tied high: `done`=1 after edge k+(N_STG-1)(GAP+1)+1. For the defaults this is k+16.
- `ready` falling at edge j → `en`, `busy` and `done` are 0 after edge j.
- `retry` at edge j → IDLE after edge j; `en[0]` is high again after edge j+1 if `ready`=1.

## Test plan
- Release reset, `ready`=1 at edge 8, `ack`=4'hF, defaults:
  - `en` steps 1→3→7→F after edges 8, 13, 18, 23.
  - `done`=1 after edge 24; `busy`=0 from edge 24.
- Ack timing: `ack[1]` held low, all other acks high, TIMEOUT=16.
  - `en[1]` rises after edge 13; ERR after edge 29.
  - `en`=0, `err`=1, `err_stg`=1.
  - `retry` pulse at edge 35 → `err`=0; `en[0]`=1 after edge 36.
- Boundary ack: `ack[0]` rises exactly at the TIMEOUT-th edge → stage accepted, no ERR.
- `ready` dropped mid-GAP of stage 2 → all outputs 0 on the next edge.
  - `ready` re-raised → sequence restarts from stage 0.
- Async reset asserted while `en`=3 and `busy`=1:
  - `en`, `busy`, `done`, `err` go to 0 without a clock edge.
  - Sequence runs normally after release.
- Early-ack check: `ack[3]`=1 from the start, `ack[2]` delayed 5 cycles.
  - `en[3]` still rises only GAP cycles after `ack[2]` is accepted.
  - `done` follows one edge later.
